// File: rtl/register_pipe_if.sv
// register_pipe_if: input/output handshake bundle for register_pipe.
// The flush signal exists only when REGISTER_PIPE_FLUSH_EN is defined.
interface register_pipe_if #(
  parameter int unsigned BUS_WIDTH = 32
);
  logic [BUS_WIDTH-1:0] in;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] out;
  logic                 out_valid;
  logic                 out_ready;
`ifdef REGISTER_PIPE_FLUSH_EN
  logic                 flush;

  // Environment side: produces words, consumes results, may flush.
  modport master (
    output in, in_valid, out_ready, flush,
    input  in_ready, out, out_valid
  );

  // Pipe side.
  modport slave (
    input  in, in_valid, out_ready, flush,
    output in_ready, out, out_valid
  );
`else
  // Environment side: produces words and consumes results.
  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  // Pipe side.
  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid
  );
`endif
endinterface

// File: rtl/register_pipe.sv
// register_pipe: DEPTH-stage valid/ready register slice with bubble collapse.
// Optional synchronous flush of all held words when REGISTER_PIPE_FLUSH_EN is defined.
module register_pipe #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned DEPTH     = 2    // legal range 1..16
) (
  input  logic           clk,
  input  logic           rst_n,
  register_pipe_if.slave bus
);
  localparam int unsigned LAST = DEPTH - 1;

  logic [DEPTH-1:0]                valid;
  logic [DEPTH-1:0]                adv;
  logic [DEPTH-1:0][BUS_WIDTH-1:0] data;
  logic                            flush_c;

`ifdef REGISTER_PIPE_FLUSH_EN
  assign flush_c = bus.flush;
`else
  assign flush_c = 1'b0;
`endif

  // A stage may advance when the consumer takes the word or any stage from it
  // to the output is empty; written flat so there is no combinational chain.
  for (genvar g = 0; g < DEPTH; g++) begin : g_adv
    assign adv[g] = bus.out_ready | ~(&valid[LAST:g]);
  end

  // Data follows only real words, so a bubble never disturbs out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      data  <= '0;
    end else if (flush_c) begin
      valid <= '0;
    end else begin
      if (adv[0]) begin
        valid[0] <= bus.in_valid;
        if (bus.in_valid) data[0] <= bus.in;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          valid[i] <= valid[i-1];
          if (valid[i-1]) data[i] <= data[i-1];
        end
      end
    end
  end

  assign bus.out       = data[LAST];
  assign bus.out_valid = valid[LAST];
  assign bus.in_ready  = adv[0];

endmodule

// File: tb/tb_register_pipe.sv
// tb_register_pipe: directed checks of register_pipe at DEPTH 2, 3 and 4.
// Flush scenario is included when REGISTER_PIPE_FLUSH_EN is defined.
module tb_register_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  register_pipe_if #(.BUS_WIDTH(32)) p2 ();
  register_pipe_if #(.BUS_WIDTH(32)) p3 ();
  register_pipe_if #(.BUS_WIDTH(32)) p4 ();

  register_pipe #(.BUS_WIDTH(32), .DEPTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(p2));
  register_pipe #(.BUS_WIDTH(32), .DEPTH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(p3));
  register_pipe #(.BUS_WIDTH(32), .DEPTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(p4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    p2.in = '0; p2.in_valid = 1'b0; p2.out_ready = 1'b0;
    p3.in = '0; p3.in_valid = 1'b0; p3.out_ready = 1'b0;
    p4.in = '0; p4.in_valid = 1'b0; p4.out_ready = 1'b0;
`ifdef REGISTER_PIPE_FLUSH_EN
    p2.flush = 1'b0; p3.flush = 1'b0; p4.flush = 1'b0;
`endif

    // Reset state
    repeat (2) cyc();
    #1;
    check("rst_out_valid_d2", 32'(p2.out_valid), 32'd0);
    check("rst_out_d2",       p2.out,            32'd0);
    check("rst_out_valid_d3", 32'(p3.out_valid), 32'd0);
    check("rst_out_d4",       p4.out,            32'd0);
    rst_n = 1'b1;
    cyc(); #1;
    check("rst_in_ready_d2", 32'(p2.in_ready), 32'd1);
    check("rst_in_ready_d3", 32'(p3.in_ready), 32'd1);
    check("rst_in_ready_d4", 32'(p4.in_ready), 32'd1);

    // 1: DEPTH=2 streaming 1..8, word e+1 driven at step e shows at step e+2
    p2.out_ready = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      p2.in_valid = (e < 8);
      p2.in       = 32'(e + 1);
      #1;
      if (e < 8) check("t1_in_ready", 32'(p2.in_ready), 32'd1);
      check("t1_out_valid", 32'(p2.out_valid), 32'((e >= 2) && (e <= 9)));
      if (e >= 2 && e <= 9) check("t1_out", p2.out, 32'(e - 1));
      cyc();
    end
    p2.in_valid = 1'b0;

    // 2: DEPTH=3 stalled, push A..D, D refused until out_ready rises
    p3.out_ready = 1'b0;
    p3.in_valid = 1'b1; p3.in = 32'hA; #1; check("t2_rdy_a", 32'(p3.in_ready), 32'd1); cyc();
    p3.in = 32'hB; #1; check("t2_rdy_b", 32'(p3.in_ready), 32'd1); cyc();
    p3.in = 32'hC; #1; check("t2_rdy_c", 32'(p3.in_ready), 32'd1); cyc();
    p3.in = 32'hD; #1;
    check("t2_rdy_d",  32'(p3.in_ready),  32'd0);
    check("t2_full_v", 32'(p3.out_valid), 32'd1);
    check("t2_full_o", p3.out,            32'hA);
    cyc(); #1;
    check("t2_hold_rdy", 32'(p3.in_ready), 32'd0);
    check("t2_hold_o",   p3.out,           32'hA);
    cyc();
    p3.out_ready = 1'b1; #1;
    check("t2_rdy_comb", 32'(p3.in_ready), 32'd1);
    check("t2_out_a",    p3.out,           32'hA);
    cyc();
    p3.in_valid = 1'b0; #1; check("t2_out_b", p3.out, 32'hB); cyc();
    #1; check("t2_out_c", p3.out, 32'hC); cyc();
    #1; check("t2_out_d", p3.out, 32'hD);
    check("t2_out_d_v", 32'(p3.out_valid), 32'd1);
    cyc(); #1;
    check("t2_empty_v", 32'(p3.out_valid), 32'd0);
    check("t2_bubble_keeps_out", p3.out, 32'hD);
    cyc();

    // 3: DEPTH=3 full with simultaneous in/out transfers
    p3.out_ready = 1'b0;
    p3.in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      p3.in = 32'(32'h10 + j);
      cyc();
    end
    p3.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      p3.in = 32'(32'h13 + j);
      #1;
      check("t3_rdy_full", 32'(p3.in_ready),  32'd1);
      check("t3_out_v",    32'(p3.out_valid), 32'd1);
      check("t3_out",      p3.out,            32'(32'h10 + j));
      cyc();
    end
    p3.in_valid = 1'b0; p3.out_ready = 1'b0; #1;
    check("t3_still_full", 32'(p3.in_ready), 32'd0);
    check("t3_out_14",     p3.out,           32'h14);
    cyc();
    p3.out_ready = 1'b1; #1; check("t3_stall_14", p3.out, 32'h14); cyc();
    #1; check("t3_out_15", p3.out, 32'h15); cyc();
    #1; check("t3_out_16", p3.out, 32'h16); cyc();
    #1; check("t3_drained", 32'(p3.out_valid), 32'd0); cyc();

    // 4: DEPTH=4 bubble collapse under stall
    p4.out_ready = 1'b0;
    p4.in_valid = 1'b1; p4.in = 32'h55; cyc();
    p4.in_valid = 1'b0; cyc(); cyc();
    #1; check("t4_not_yet", 32'(p4.out_valid), 32'd0); cyc();
    #1;
    check("t4_arrive_v", 32'(p4.out_valid), 32'd1);
    check("t4_arrive_o", p4.out,            32'h55);
    for (int j = 0; j < 3; j++) begin
      p4.in_valid = 1'b1; p4.in = 32'(32'h56 + j); #1;
      check("t4_fill_rdy", 32'(p4.in_ready), 32'd1);
      cyc();
    end
    p4.in = 32'h59; #1;
    check("t4_full_rdy", 32'(p4.in_ready), 32'd0);
    cyc();
    p4.out_ready = 1'b1; #1;
    check("t4_rel_rdy", 32'(p4.in_ready), 32'd1);
    check("t4_out_55",  p4.out,           32'h55);
    cyc();
    p4.in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("t4_drain_v", 32'(p4.out_valid), 32'd1);
      check("t4_drain_o", p4.out,            32'(32'h56 + j));
      cyc();
    end
    #1; check("t4_empty", 32'(p4.out_valid), 32'd0); cyc();

    // 5: reset mid-stream with two words held in DEPTH=2
    p2.out_ready = 1'b0;
    p2.in_valid = 1'b1; p2.in = 32'h21; cyc();
    p2.in = 32'h22; cyc();
    p2.in_valid = 1'b0; #1;
    check("t5_held_v", 32'(p2.out_valid), 32'd1);
    check("t5_held_o", p2.out,            32'h21);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; p2.out_ready = 1'b1; #1;
    check("t5_rst_v",   32'(p2.out_valid), 32'd0);
    check("t5_rst_o",   p2.out,            32'd0);
    check("t5_rst_rdy", 32'(p2.in_ready),  32'd1);
    cyc();
    for (int j = 0; j < 3; j++) begin
      #1; check("t5_gone", 32'(p2.out_valid), 32'd0); cyc();
    end

`ifdef REGISTER_PIPE_FLUSH_EN
    // 6: flush with DEPTH=3 full plus an incoming word
    p3.out_ready = 1'b0;
    p3.in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      p3.in = 32'(32'h31 + j);
      cyc();
    end
    p3.in = 32'h34; p3.out_ready = 1'b1; p3.flush = 1'b1; #1;
    check("t6_pre_o",   p3.out,           32'h31);
    check("t6_pre_rdy", 32'(p3.in_ready), 32'd1);
    cyc();
    p3.flush = 1'b0; p3.in = 32'h77; #1;
    check("t6_flush_v",   32'(p3.out_valid), 32'd0);
    check("t6_flush_o",   p3.out,            32'h31);
    check("t6_flush_rdy", 32'(p3.in_ready),  32'd1);
    cyc();
    p3.in_valid = 1'b0;
    #1; check("t6_lat1", 32'(p3.out_valid), 32'd0); cyc();
    #1; check("t6_lat2", 32'(p3.out_valid), 32'd0); cyc();
    #1;
    check("t6_77_v", 32'(p3.out_valid), 32'd1);
    check("t6_77_o", p3.out,            32'h77);
    cyc();
    #1; check("t6_after", 32'(p3.out_valid), 32'd0);
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
